// File: rtl/btb_pkg.sv
// Shared definitions for the branch target buffer: counter encodings, FSM states, counter helpers.
// Build option: BTB_HYSTERESIS_EN selects 2-bit saturating counters; otherwise a 1-bit direction bit.
package btb_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

`ifdef BTB_HYSTERESIS_EN
  localparam int unsigned CTR_W = 2;
`else
  localparam int unsigned CTR_W = 1;
`endif

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_IDLE  = 1'b1
  } btb_state_e;

  // Entry layout is {valid, tag, target, ctr}; valid lives in its own array so the sweep can clear it.
  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == CTR_ST) ? CTR_ST : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == CTR_SNT) ? CTR_SNT : c - 2'b01;
  endfunction

endpackage

// File: rtl/btb_entry_ram.sv
// BTB storage: FETCH_W registered read ports, one combinational update-probe port, one write port,
// and a separate valid-bit array cleared one entry at a time by the invalidate sweep.
module btb_entry_ram
  import btb_pkg::*;
#(
  parameter int unsigned PC_W    = 13,
  parameter int unsigned IDX_W   = 8,
  parameter int unsigned FETCH_W = 2,
  parameter int unsigned CTR_LEN = 1
) (
  input  logic                            clk_i,
  input  logic [FETCH_W*IDX_W-1:0]        rd_idx_i,
  output logic [FETCH_W-1:0]              rd_valid_o,
  output logic [FETCH_W*(PC_W-IDX_W)-1:0] rd_tag_o,
  output logic [FETCH_W*PC_W-1:0]         rd_target_o,
  output logic [FETCH_W*CTR_LEN-1:0]      rd_ctr_o,
  input  logic [IDX_W-1:0]                up_idx_i,
  output logic                            up_valid_o,
  output logic [PC_W-IDX_W-1:0]           up_tag_o,
  output logic [PC_W-1:0]                 up_target_o,
  output logic [CTR_LEN-1:0]              up_ctr_o,
  input  logic                            wr_en_i,
  input  logic [IDX_W-1:0]                wr_idx_i,
  input  logic [PC_W-IDX_W-1:0]           wr_tag_i,
  input  logic [PC_W-1:0]                 wr_target_i,
  input  logic [CTR_LEN-1:0]              wr_ctr_i,
  input  logic                            clr_en_i,
  input  logic [IDX_W-1:0]                clr_idx_i
);

  localparam int unsigned ENTRIES = 1 << IDX_W;
  localparam int unsigned TAG_W   = PC_W - IDX_W;
  localparam int unsigned DATA_W  = TAG_W + PC_W + CTR_LEN;

  logic [ENTRIES-1:0] valid_q;
  logic [DATA_W-1:0]  data_q [ENTRIES];
  logic [DATA_W-1:0]  up_data;

  always_ff @(posedge clk_i) begin
    if (clr_en_i) begin
      valid_q[clr_idx_i] <= 1'b0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      data_q[wr_idx_i] <= {wr_tag_i, wr_target_i, wr_ctr_i};
    end
  end

  // Registered reads sample pre-write contents, giving read-before-write on index collisions.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < FETCH_W; i++) begin
      rd_valid_o[i] <= valid_q[rd_idx_i[i*IDX_W +: IDX_W]];
      {rd_tag_o[i*TAG_W +: TAG_W], rd_target_o[i*PC_W +: PC_W], rd_ctr_o[i*CTR_LEN +: CTR_LEN]}
        <= data_q[rd_idx_i[i*IDX_W +: IDX_W]];
    end
  end

  assign up_valid_o = valid_q[up_idx_i];
  assign up_data    = data_q[up_idx_i];
  assign {up_tag_o, up_target_o, up_ctr_o} = up_data;

endmodule

// File: rtl/btb_predict.sv
// Multi-port branch target buffer with registered lookup, execute-stage training and sequenced invalidate.
// Build option: BTB_HYSTERESIS_EN (2-bit saturating counters instead of a 1-bit direction bit).
module btb_predict
  import btb_pkg::*;
#(
  parameter int unsigned PC_W    = 13,
  parameter int unsigned IDX_W   = 8,
  parameter int unsigned FETCH_W = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [FETCH_W*PC_W-1:0] fetch_pc,
  output logic [FETCH_W-1:0]      pred_hit,
  output logic [FETCH_W-1:0]      pred_taken,
  output logic [FETCH_W*PC_W-1:0] pred_target,
  input  logic                    upd_valid,
  input  logic [PC_W-1:0]         upd_pc,
  input  logic [PC_W-1:0]         upd_target,
  input  logic                    upd_taken,
  input  logic                    inv_req,
  output logic                    busy
);

  localparam int unsigned TAG_W = PC_W - IDX_W;

  btb_state_e state_q, state_d;
  logic [IDX_W-1:0]         ptr_q, ptr_d;
  logic                     lookup_en_q;
  logic [FETCH_W*TAG_W-1:0] ftag_q;
  logic [FETCH_W*IDX_W-1:0] rd_idx;

  logic [FETCH_W-1:0]         rd_valid;
  logic [FETCH_W*TAG_W-1:0]   rd_tag;
  logic [FETCH_W*PC_W-1:0]    rd_target;
  logic [FETCH_W*CTR_W-1:0]   rd_ctr;

  logic                 up_valid, up_hit;
  logic [TAG_W-1:0]     up_tag;
  logic [PC_W-1:0]      up_target;
  logic [CTR_W-1:0]     up_ctr;
  logic                 wr_en, clr_en;
  logic [PC_W-1:0]      wr_target;
  logic [CTR_W-1:0]     wr_ctr, ctr_alloc, ctr_inc, ctr_dec;

  always_comb begin
    rd_idx = '0;
    for (int unsigned i = 0; i < FETCH_W; i++) begin
      rd_idx[i*IDX_W +: IDX_W] = fetch_pc[i*PC_W +: IDX_W];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_SWEEP;
      ptr_q       <= '0;
      lookup_en_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lookup_en_q <= (state_q == ST_IDLE);
    end
  end

  always_ff @(posedge CLK) begin
    for (int unsigned i = 0; i < FETCH_W; i++) begin
      ftag_q[i*TAG_W +: TAG_W] <= fetch_pc[i*PC_W+IDX_W +: TAG_W];
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_en  = 1'b0;
    case (state_q)
      ST_SWEEP: begin
        clr_en = 1'b1;
        if (inv_req) begin
          ptr_d = '0;
        end else if (ptr_q == '1) begin
          ptr_d   = '0;
          state_d = ST_IDLE;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end
      ST_IDLE: begin
        if (inv_req) begin
          ptr_d   = '0;
          state_d = ST_SWEEP;
        end
      end
      default: state_d = ST_SWEEP;
    endcase
  end

`ifdef BTB_HYSTERESIS_EN
  assign ctr_alloc = CTR_WT;
  assign ctr_inc   = sat_inc(up_ctr);
  assign ctr_dec   = sat_dec(up_ctr);
`else
  assign ctr_alloc = 1'b1;
  assign ctr_inc   = 1'b1;
  assign ctr_dec   = 1'b0;
`endif

  assign up_hit = up_valid && (up_tag == upd_pc[PC_W-1:IDX_W]);

  // Hits always rewrite the whole entry; a not-taken hit writes back the stored target unchanged.
  always_comb begin
    wr_en     = 1'b0;
    wr_target = upd_target;
    wr_ctr    = ctr_alloc;
    if (state_q == ST_IDLE && upd_valid) begin
      if (up_hit) begin
        wr_en = 1'b1;
        if (upd_taken) begin
          wr_ctr = ctr_inc;
        end else begin
          wr_ctr    = ctr_dec;
          wr_target = up_target;
        end
      end else if (upd_taken) begin
        wr_en = 1'b1;
      end
    end
  end

  btb_entry_ram #(
    .PC_W    (PC_W),
    .IDX_W   (IDX_W),
    .FETCH_W (FETCH_W),
    .CTR_LEN (CTR_W)
  ) u_ram (
    .clk_i       (CLK),
    .rd_idx_i    (rd_idx),
    .rd_valid_o  (rd_valid),
    .rd_tag_o    (rd_tag),
    .rd_target_o (rd_target),
    .rd_ctr_o    (rd_ctr),
    .up_idx_i    (upd_pc[IDX_W-1:0]),
    .up_valid_o  (up_valid),
    .up_tag_o    (up_tag),
    .up_target_o (up_target),
    .up_ctr_o    (up_ctr),
    .wr_en_i     (wr_en),
    .wr_idx_i    (upd_pc[IDX_W-1:0]),
    .wr_tag_i    (upd_pc[PC_W-1:IDX_W]),
    .wr_target_i (wr_target),
    .wr_ctr_i    (wr_ctr),
    .clr_en_i    (clr_en),
    .clr_idx_i   (ptr_q)
  );

  always_comb begin
    pred_hit    = '0;
    pred_taken  = '0;
    pred_target = '0;
    for (int unsigned i = 0; i < FETCH_W; i++) begin
      if (lookup_en_q && rd_valid[i] && (rd_tag[i*TAG_W +: TAG_W] == ftag_q[i*TAG_W +: TAG_W])) begin
        pred_hit[i]                  = 1'b1;
        pred_taken[i]                = rd_ctr[i*CTR_W + CTR_W - 1];
        pred_target[i*PC_W +: PC_W]  = rd_target[i*PC_W +: PC_W];
      end
    end
  end

  assign busy = (state_q == ST_SWEEP);

endmodule
